// File: rtl/boot_loader_pkg.sv
// boot_loader shared types.
// Frame field widths and loader FSM state encoding.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_COUNT_HI,
    S_COUNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int COUNT_W = 16;
  localparam int CSUM_W  = 8;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// word_assembler: packs bytes MSB-first into a word.
// word/word_valid already include the byte offered this cycle.
module word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign word       = DATA_WIDTH'({shift_q, byte_in});
  assign word_valid = byte_valid && (cnt_q == CNT_W'(BYTES - 1));

  // Shift in accepted bytes; wrap the byte counter at a word boundary.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = word;
      cnt_d   = word_valid ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Assembler state register.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    cnt_q   <= cnt_d;
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: framed byte-stream program loader.
// Writes words from address 0, checks XOR sum, releases CPU.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_run
);

  localparam int IDX_W = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [IDX_W-1:0]      n_q, n_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CSUM_W-1:0]     csum_q, csum_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rdy_q, rdy_d;

  logic                  xfer;
  logic [COUNT_W-1:0]    n_full;
  logic                  n_big;
  logic                  n_zero;
  logic                  asm_valid;
  logic                  asm_clr;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;
  logic                  last_word;

  assign xfer      = in_valid && rdy_q;
  assign n_full    = {hi_q, in_data};
  assign n_big     = 32'(n_full) > (32'd1 << ADDR_WIDTH);
  assign n_zero    = (n_full == '0);
  assign asm_valid = xfer && (state_q == S_DATA);
  assign asm_clr   = rst ||
                     (state_q == S_COUNT_LO &&
                      state_d == S_DATA);
  assign last_word = (idx_q + IDX_W'(1)) == n_q;

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk        (clk),
    .clr        (asm_clr),
    .byte_valid (asm_valid),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COUNT_HI;
      hi_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
    end
  end

  // Frame sequencing: count, payload, checksum, then terminal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COUNT_HI: if (xfer) state_d = S_COUNT_LO;
      S_COUNT_LO: begin
        if (xfer) begin
          if (n_big)       state_d = S_ERROR;
          else if (n_zero) state_d = S_CSUM;
          else             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (asm_valid && word_valid && last_word)
          state_d = S_CSUM;
      end
      S_CSUM: begin
        if (xfer)
          state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = state_q;
    endcase
  end

  // Count capture, checksum, write port and ready generation.
  always_comb begin
    hi_d    = hi_q;
    n_d     = n_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdy_d   = (state_d != S_DONE) && (state_d != S_ERROR);
    if (xfer && state_q == S_COUNT_HI) hi_d = in_data;
    if (xfer && state_q == S_COUNT_LO) n_d = IDX_W'(n_full);
    if (asm_valid) begin
      csum_d = csum_q ^ in_data;
      if (word_valid) begin
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_WIDTH-1:0];
        wdata_d = word;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  assign in_ready     = rdy_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = idx_q;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign cpu_run      = (state_q == S_DONE);

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized frames against a frame-level model.
// Expected writes, timing and outcome derive from the frame bytes.
module tb_boot_loader;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   words_loaded;
  logic          done;
  logic          error;
  logic          cpu_run;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0]   ew[$];
  logic [7:0]    frm[$];
  int            hs[$];
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  logic [AW:0]   wl[$];
  int            wc[$];

  boot_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error),
    .cpu_run      (cpu_run)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wl.push_back(words_loaded);
      wc.push_back(cyc);
    end
  end

  task automatic clear_capture();
    wa.delete();
    wd.delete();
    wl.delete();
    wc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_capture();
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Frame = 16-bit count, words MSB first, XOR of payload ^ cx.
  task automatic build_frame(input int n, input logic [7:0] cx);
    logic [7:0] cs;
    logic [7:0] b;
    frm.delete();
    hs.delete();
    frm.push_back(8'((n >> 8) & 255));
    frm.push_back(8'(n & 255));
    cs = 8'h00;
    foreach (ew[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'((ew[i] >> (8 * k)) & 32'hFF);
        frm.push_back(b);
        cs = cs ^ b;
      end
    end
    frm.push_back(cs ^ cx);
  endtask

  task automatic send_bytes(input int first, input int last,
                            input int gap);
    bit ok;
    int g;
    for (int i = first; i <= last; i++) begin
      g = 0;
      while (g < 3 && int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        @(negedge clk);
        g++;
      end
      in_valid = 1'b1;
      in_data = frm[i];
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        if (in_ready === 1'b1) begin
          @(posedge clk);
          @(negedge clk);
          hs.push_back(cyc);
          ok = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL handshake byte %0d: in_ready=%b required 1",
                 i, in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, done, error, cpu_run} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {in_ready, mem_we, done, error, cpu_run});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_wport: got %h/%h required 0/0",
               mem_addr, mem_wdata);
    end
    checks++;
    if (words_loaded !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", in_ready);
    end
  endtask

  // Full-frame scenario; frame payload comes from ew.
  task automatic test_frame(input string name, input logic [7:0] cx,
                            input int gap);
    int  n;
    bit  ok_exp;
    int  nw;
    n = ew.size();
    ok_exp = (cx == 8'h00);
    do_reset();
    build_frame(n, cx);
    send_bytes(0, frm.size() - 2, gap);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s pre_csum: done=%b ready=%b required 0/1",
               name, done, in_ready);
    end
    send_bytes(frm.size() - 1, frm.size() - 1, gap);
    checks++;
    if ({done, cpu_run, error, in_ready} !==
        {ok_exp, ok_exp, !ok_exp, 1'b0}) begin
      errors++;
      $display("FAIL %s status: done/run/err/rdy=%b required %b",
               name, {done, cpu_run, error, in_ready},
               {ok_exp, ok_exp, !ok_exp, 1'b0});
    end
    checks++;
    if (wa.size() != n || words_loaded !== (AW + 1)'(n)) begin
      errors++;
      $display("FAIL %s write_count: got %0d/%0d required %0d",
               name, wa.size(), words_loaded, n);
    end
    nw = (wa.size() < n) ? wa.size() : n;
    for (int k = 0; k < nw; k++) begin
      checks++;
      if (wa[k] !== AW'(k) || wd[k] !== ew[k] ||
          wl[k] !== (AW + 1)'(k + 1) || wc[k] != hs[5 + 4 * k]) begin
        errors++;
        $display("FAIL %s write%0d: a=%h d=%h wl=%0d c=%0d required %h %h %0d %0d",
                 name, k, wa[k], wd[k], wl[k], wc[k],
                 AW'(k), ew[k], k + 1, hs[5 + 4 * k]);
      end
    end
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || done !== ok_exp || wa.size() != n) begin
      errors++;
      $display("FAIL %s terminal_hold: rdy=%b done=%b writes=%0d required 0 %b %0d",
               name, in_ready, done, wa.size(), ok_exp, n);
    end
  endtask

  task automatic test_count_overflow();
    do_reset();
    ew.delete();
    build_frame((1 << AW) + 1, 8'h00);
    send_bytes(0, 1, 0);
    checks++;
    if ({error, done, cpu_run, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL count_overflow: err/done/run/rdy=%b required 1000",
               {error, done, cpu_run, in_ready});
    end
    in_valid = 1'b1;
    in_data = 8'h00;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wa.size() != 0 || words_loaded !== '0 || error !== 1'b1 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL count_overflow_hold: writes=%0d wl=%0d err=%b rdy=%b required 0 0 1 0",
               wa.size(), words_loaded, error, in_ready);
    end
  endtask

  task automatic test_abort_mid_word();
    do_reset();
    ew = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    build_frame(3, 8'h00);
    send_bytes(0, 7, 0);
    checks++;
    if (wa.size() != 1) begin
      errors++;
      $display("FAIL abort_prefix: writes=%0d required 1", wa.size());
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_capture();
    checks++;
    if (words_loaded !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: wl=%0d rdy=%b required 0 0",
               words_loaded, in_ready);
    end
    ew = '{32'hCAFEF00D};
    build_frame(1, 8'h00);
    send_bytes(0, frm.size() - 1, 0);
    checks++;
    if (wa.size() != 1) begin
      errors++;
      $display("FAIL abort_refill_count: writes=%0d required 1",
               wa.size());
    end else begin
      checks++;
      if (wa[0] !== '0 || wd[0] !== 32'hCAFEF00D) begin
        errors++;
        $display("FAIL abort_refill_word: got %h@%h required cafef00d@00",
                 wd[0], wa[0]);
      end
    end
    checks++;
    if (done !== 1'b1 || cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL abort_refill_done: done=%b run=%b required 1 1",
               done, cpu_run);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] cx;
    int n;
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(6, 1));
      ew.delete();
      for (int i = 0; i < n; i++) ew.push_back($urandom);
      cx = ($urandom_range(1) == 0) ? 8'h00
                                    : 8'($urandom_range(255, 1));
      test_frame("random", cx, 40);
    end
  endtask

  initial begin
    test_reset();
    ew = '{32'h12345678, 32'hDEADBEEF};
    test_frame("good_n2", 8'h00, 0);
    test_frame("bad_csum_n2", 8'h01, 0);
    ew.delete();
    test_frame("zero_good", 8'h00, 0);
    test_frame("zero_bad", 8'h5A, 0);
    test_count_overflow();
    ew.delete();
    for (int i = 0; i < (1 << AW); i++) ew.push_back($urandom);
    test_frame("full_image", 8'h00, 30);
    test_abort_mid_word();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
